// File: rtl/modport_fifo.sv
// Single-clock synchronous FIFO with a registered read port and occupancy-decoded
// full / empty / almost-full / almost-empty status flags.
module modport_fifo #(
    parameter int unsigned DATA_W       = 128,
    parameter int unsigned DEPTH        = 1024,
    parameter int unsigned ALM_EMPTY_TH = 2,
    parameter int unsigned ALM_FULL_TH  = 1022
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              i_wren,
    input  logic              i_rden,
    input  logic [DATA_W-1:0] i_wrdata,
    output logic              o_full,
    output logic              o_empty,
    output logic              o_alm_full,
    output logic              o_alm_empty,
    output logic [DATA_W-1:0] o_rddata
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    localparam logic [CW-1:0] CNT_FULL   = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_AFULL  = CW'(ALM_FULL_TH);
    localparam logic [CW-1:0] CNT_AEMPTY = CW'(ALM_EMPTY_TH);

    logic [DATA_W-1:0] mem [DEPTH];

    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic [DATA_W-1:0] rddata_q, rddata_d;

    logic full, empty;
    logic wr_accept, rd_accept;

    // Flags come straight from the count register, i.e. the state after the last edge.
    always_comb begin
        full        = (count_q == CNT_FULL);
        empty       = (count_q == '0);
        o_full      = full;
        o_empty     = empty;
        o_alm_full  = (count_q >= CNT_AFULL);
        o_alm_empty = (count_q <= CNT_AEMPTY);
        o_rddata    = rddata_q;
    end

    always_comb begin
        wr_accept = i_wren && !full;
        rd_accept = i_rden && !empty;
    end

    // DEPTH is a power of two, so natural AW-bit overflow gives the modulo wrap.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        rddata_d = rddata_q;

        if (wr_accept) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (rd_accept) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
            rddata_d = mem[rd_ptr_q];
        end

        unique case ({wr_accept, rd_accept})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            rddata_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            rddata_q <= rddata_d;
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem[wr_ptr_q] <= i_wrdata;
        end
    end

endmodule

// File: tb/tb_modport_fifo.sv
// Directed, table-driven bench for modport_fifo: reset, basic traffic, fill/drain,
// underflow, simultaneous access, pointer wrap and mid-operation reset.
module tb_modport_fifo;

    localparam int DW    = 128;
    localparam int DEPTH = 1024;

    logic          clk;
    logic          rstn;
    logic          i_wren;
    logic          i_rden;
    logic [DW-1:0] i_wrdata;
    logic          o_full;
    logic          o_empty;
    logic          o_alm_full;
    logic          o_alm_empty;
    logic [DW-1:0] o_rddata;

    int checks;
    int errors;

    modport_fifo #(
        .DATA_W      (DW),
        .DEPTH       (DEPTH),
        .ALM_EMPTY_TH(2),
        .ALM_FULL_TH (1022)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .i_wren     (i_wren),
        .i_rden     (i_rden),
        .i_wrdata   (i_wrdata),
        .o_full     (o_full),
        .o_empty    (o_empty),
        .o_alm_full (o_alm_full),
        .o_alm_empty(o_alm_empty),
        .o_rddata   (o_rddata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // {full, empty, alm_full, alm_empty}
    typedef struct {
        logic          wren;
        logic          rden;
        logic [DW-1:0] wdata;
        logic [3:0]    flags;
        logic [DW-1:0] rdata;
    } vec_t;

    vec_t vecs[11];

    function automatic logic [3:0] exp_flags(input int n);
        return {n == DEPTH, n == 0, n >= 1022, n <= 2};
    endfunction

    function automatic logic [3:0] dut_flags();
        return {o_full, o_empty, o_alm_full, o_alm_empty};
    endfunction

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [DW-1:0] a5;
    logic [DW-1:0] q[$];
    logic [DW-1:0] last_rd;
    int            nxt;

    initial begin
        checks   = 0;
        errors   = 0;
        rstn     = 1'b1;
        i_wren   = 1'b0;
        i_rden   = 1'b0;
        i_wrdata = '0;
        a5       = {16{8'hA5}};

        vecs[0]  = '{1'b1, 1'b0, a5,         4'b0001, '0};
        vecs[1]  = '{1'b1, 1'b0, 128'h1234,  4'b0001, '0};
        vecs[2]  = '{1'b0, 1'b1, '0,         4'b0001, a5};
        vecs[3]  = '{1'b0, 1'b1, '0,         4'b0101, 128'h1234};
        vecs[4]  = '{1'b0, 1'b1, '0,         4'b0101, 128'h1234};  // underflow
        vecs[5]  = '{1'b1, 1'b1, 128'hBEEF,  4'b0001, 128'h1234};  // rd+wr while empty
        vecs[6]  = '{1'b1, 1'b0, 128'h2,     4'b0001, 128'h1234};
        vecs[7]  = '{1'b1, 1'b0, 128'h3,     4'b0000, 128'h1234};
        vecs[8]  = '{1'b0, 1'b1, '0,         4'b0001, 128'hBEEF};
        vecs[9]  = '{1'b0, 1'b1, '0,         4'b0001, 128'h2};
        vecs[10] = '{1'b0, 1'b1, '0,         4'b0101, 128'h3};

        // Asynchronous reset between edges.
        #2 rstn = 1'b0;
        #1;
        chk("reset_flags", DW'(dut_flags()), DW'(4'b0101));
        chk("reset_rddata", o_rddata, '0);
        #10 rstn = 1'b1;

        for (int i = 0; i < 11; i++) begin
            i_wren   = vecs[i].wren;
            i_rden   = vecs[i].rden;
            i_wrdata = vecs[i].wdata;
            step();
            chk($sformatf("vec%0d_flags", i), DW'(dut_flags()), DW'(vecs[i].flags));
            chk($sformatf("vec%0d_rddata", i), o_rddata, vecs[i].rdata);
        end
        i_rden = 1'b0;

        // Fill to capacity with 1..1024.
        for (int n = 1; n <= DEPTH; n++) begin
            i_wren   = 1'b1;
            i_wrdata = DW'(n);
            step();
            chk($sformatf("fill%0d_flags", n), DW'(dut_flags()), DW'(exp_flags(n)));
        end
        i_wrdata = 128'hDEAD;
        step();
        chk("overflow_flags", DW'(dut_flags()), DW'(exp_flags(DEPTH)));
        chk("overflow_rddata", o_rddata, 128'h3);

        // Read and write at full: read 1 accepted, write dropped.
        i_wrdata = 128'hFACE;
        i_rden   = 1'b1;
        step();
        chk("full_rw_flags", DW'(dut_flags()), DW'(exp_flags(1023)));
        chk("full_rw_rddata", o_rddata, 128'h1);
        i_wren = 1'b0;
        for (int n = 2; n <= DEPTH; n++) begin
            step();
            chk($sformatf("drain%0d_data", n), o_rddata, DW'(n));
            chk($sformatf("drain%0d_flags", n), DW'(dut_flags()), DW'(exp_flags(DEPTH - n)));
        end
        step();
        chk("drain_underflow", o_rddata, DW'(DEPTH));
        i_rden = 1'b0;

        // Simultaneous read/write at occupancy 5.
        for (int n = 0; n < 5; n++) begin
            i_wren   = 1'b1;
            i_wrdata = DW'(100 + n);
            step();
        end
        chk("occ5_flags", DW'(dut_flags()), DW'(4'b0000));
        i_rden = 1'b1;
        for (int n = 0; n < 10; n++) begin
            i_wrdata = DW'(105 + n);
            step();
            chk($sformatf("rw%0d_data", n), o_rddata, DW'(100 + n));
            chk($sformatf("rw%0d_flags", n), DW'(dut_flags()), DW'(4'b0000));
        end
        i_wren = 1'b0;
        for (int n = 0; n < 5; n++) begin
            step();
            chk($sformatf("rwdrain%0d", n), o_rddata, DW'(110 + n));
        end
        i_rden = 1'b0;
        step();
        chk("rw_empty", DW'(dut_flags()), DW'(4'b0101));

        // Streaming across several pointer wraps against a reference queue.
        nxt     = 5000;
        last_rd = DW'(114);
        for (int c = 0; c < 4000; c++) begin
            i_wren   = (c < 3000);
            i_rden   = (c % 3 != 0) || (c >= 3000);
            i_wrdata = DW'(nxt);
            if (i_rden && q.size() > 0) last_rd = q.pop_front();
            if (i_wren && q.size() + ((i_rden && last_rd !== 'x) ? 0 : 0) < DEPTH) begin
                q.push_back(DW'(nxt));
                nxt++;
            end
            step();
            chk($sformatf("wrap%0d_data", c), o_rddata, last_rd);
            chk($sformatf("wrap%0d_flags", c), DW'(dut_flags()), DW'(exp_flags(q.size())));
        end
        i_wren = 1'b0;
        i_rden = 1'b0;

        // Reset with 7 entries stored.
        for (int n = 0; n < 7; n++) begin
            i_wren   = 1'b1;
            i_wrdata = DW'(700 + n);
            step();
        end
        i_wren = 1'b0;
        chk("pre_rst_flags", DW'(dut_flags()), DW'(exp_flags(7)));
        #3 rstn = 1'b0;
        #1;
        chk("midrst_flags", DW'(dut_flags()), DW'(4'b0101));
        chk("midrst_rddata", o_rddata, '0);
        #2 rstn = 1'b1;
        i_rden = 1'b1;
        step();
        i_rden = 1'b0;
        chk("post_rst_rddata", o_rddata, '0);
        chk("post_rst_flags", DW'(dut_flags()), DW'(4'b0101));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
